// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcodes, ALU codes, mux-select encodings and branch-condition helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALU_MODE_ADD   = 2'b00,
    ALU_MODE_SUB   = 2'b01,
    ALU_MODE_FUNCT = 2'b10
  } alu_mode_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  // Carry is no-borrow, so unsigned less-than is !Carry.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic neg, input logic carry, input logic ovf);
    logic taken_s;
    case (funct3)
      3'b000:  taken_s = zero;
      3'b001:  taken_s = ~zero;
      3'b100:  taken_s = neg ^ ovf;
      3'b101:  taken_s = ~(neg ^ ovf);
      3'b110:  taken_s = ~carry;
      3'b111:  taken_s = carry;
      default: taken_s = 1'b0;
    endcase
    return taken_s;
  endfunction

  function automatic logic branch_legal(input logic [2:0] funct3, input logic full_branch);
    logic ok_s;
    case (funct3)
      3'b000:                         ok_s = 1'b1;
      3'b001, 3'b100, 3'b101,
      3'b110, 3'b111:                 ok_s = full_branch;
      default:                        ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// datapath enables and mux selects out.
interface mc_ctrl_if #(parameter int ALU_CTRL_W = 3);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic                  funct75;
  logic                  Zero;
  logic                  Negative;
  logic                  Carry;
  logic                  Overflow;
  logic                  mem_ready;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [1:0]            ImmSrc;
  logic                  RegWrite;
  logic                  illegal;
  logic [3:0]            state_o;

  modport master (
    input  op, funct3, funct75, Zero, Negative, Carry, Overflow, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal, state_o
  );

  modport slave (
    output op, funct3, funct75, Zero, Negative, Carry, Overflow, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal, state_o
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-control decoder. legal reflects funct3 support only, so it
// is meaningful in DECODE even while the ALU is forced to add.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  alu_mode_e             mode,
  input  logic [2:0]            funct3,
  input  logic                  funct75,
  input  logic                  op5,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  legal
);

  logic [2:0] funct_code_s;
  logic [2:0] code_s;

  // funct3/funct7 decode; only R-type (op5=1) honours funct7[5] for sub
  always_comb begin
    funct_code_s = ALU_ADD;
    legal        = 1'b1;
    case (funct3)
      3'b000:  funct_code_s = (op5 && funct75) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_code_s = ALU_SLT;
      3'b110:  funct_code_s = ALU_OR;
      3'b111:  funct_code_s = ALU_AND;
      default: begin
        funct_code_s = ALU_ADD;
        legal        = 1'b0;
      end
    endcase
  end

  // mode select between fixed add/sub and the decoded operation
  always_comb begin
    code_s = ALU_ADD;
    case (mode)
      ALU_MODE_ADD:   code_s = ALU_ADD;
      ALU_MODE_SUB:   code_s = ALU_SUB;
      ALU_MODE_FUNCT: code_s = funct_code_s;
      default:        code_s = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code_s);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: Moore FSM driving datapath enables
// and selects, with memory-ready stalls and an illegal-instruction trap state.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W    = 3,
  parameter int FULL_BRANCH   = 1,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  state_e                state_r;
  state_e                next_s;
  alu_mode_e             alu_mode_s;
  logic [ALU_CTRL_W-1:0] alu_ctrl_s;
  logic                  f3_legal_s;
  logic                  mem_ready_s;
  logic                  full_branch_s;
  logic                  pcwrite_s, irwrite_s, memwrite_s, regwrite_s, adrsrc_s, illegal_s;
  logic [1:0]            resultsrc_s, srca_s, srcb_s, immsrc_s;

  assign mem_ready_s   = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
  assign full_branch_s = (FULL_BRANCH != 0);

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .mode        (alu_mode_s),
    .funct3      (bus.funct3),
    .funct75     (bus.funct75),
    .op5         (bus.op[5]),
    .alu_control (alu_ctrl_s),
    .legal       (f3_legal_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // next-state logic
  always_comb begin
    next_s = ST_FETCH;
    case (state_r)
      ST_FETCH:    next_s = mem_ready_s ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: next_s = ST_MEMADR;
          OP_RTYPE:          next_s = f3_legal_s ? ST_EXECR : ST_TRAP;
          OP_ITYPE:          next_s = f3_legal_s ? ST_EXECI : ST_TRAP;
          OP_BRANCH:         next_s = branch_legal(bus.funct3, full_branch_s) ? ST_BRANCH : ST_TRAP;
          OP_JAL:            next_s = ST_JAL;
          default:           next_s = ST_TRAP;
        endcase
      end
      ST_MEMADR:   next_s = bus.op[5] ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  next_s = mem_ready_s ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:    next_s = ST_FETCH;
      ST_MEMWRITE: next_s = mem_ready_s ? ST_FETCH : ST_MEMWRITE;
      ST_EXECR:    next_s = ST_ALUWB;
      ST_EXECI:    next_s = ST_ALUWB;
      ST_ALUWB:    next_s = ST_FETCH;
      ST_BRANCH:   next_s = ST_FETCH;
      ST_JAL:      next_s = ST_ALUWB;
      ST_TRAP:     next_s = ST_FETCH;
      default:     next_s = ST_FETCH;
    endcase
  end

  // per-state datapath controls; anything not named stays 0 / select 00
  always_comb begin
    pcwrite_s   = 1'b0;
    irwrite_s   = 1'b0;
    memwrite_s  = 1'b0;
    regwrite_s  = 1'b0;
    adrsrc_s    = 1'b0;
    illegal_s   = 1'b0;
    resultsrc_s = RES_ALUOUT;
    srca_s      = SRCA_PC;
    srcb_s      = SRCB_RS2;
    immsrc_s    = IMM_I;
    alu_mode_s  = ALU_MODE_ADD;
    case (state_r)
      ST_FETCH: begin
        srcb_s      = SRCB_FOUR;
        resultsrc_s = RES_ALURES;
        irwrite_s   = mem_ready_s;
        pcwrite_s   = mem_ready_s;
      end
      ST_DECODE: begin
        srca_s = SRCA_OLDPC;
        srcb_s = SRCB_IMM;
        case (bus.op)
          OP_STORE:  immsrc_s = IMM_S;
          OP_BRANCH: immsrc_s = IMM_B;
          OP_JAL:    immsrc_s = IMM_J;
          default:   immsrc_s = IMM_I;
        endcase
      end
      ST_MEMADR: begin
        srca_s   = SRCA_RS1;
        srcb_s   = SRCB_IMM;
        immsrc_s = bus.op[5] ? IMM_S : IMM_I;
      end
      ST_MEMREAD:  adrsrc_s = 1'b1;
      ST_MEMWB: begin
        resultsrc_s = RES_DATA;
        regwrite_s  = 1'b1;
      end
      ST_MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      ST_EXECR: begin
        srca_s     = SRCA_RS1;
        alu_mode_s = ALU_MODE_FUNCT;
      end
      ST_EXECI: begin
        srca_s     = SRCA_RS1;
        srcb_s     = SRCB_IMM;
        alu_mode_s = ALU_MODE_FUNCT;
      end
      ST_ALUWB:    regwrite_s = 1'b1;
      ST_BRANCH: begin
        srca_s     = SRCA_RS1;
        alu_mode_s = ALU_MODE_SUB;
        immsrc_s   = IMM_B;
        pcwrite_s  = branch_taken(bus.funct3, bus.Zero, bus.Negative, bus.Carry, bus.Overflow);
      end
      ST_JAL: begin
        srca_s    = SRCA_OLDPC;
        srcb_s    = SRCB_FOUR;
        immsrc_s  = IMM_J;
        pcwrite_s = 1'b1;
      end
      ST_TRAP:     illegal_s = 1'b1;
      default:     illegal_s = 1'b0;
    endcase
  end

  // write enables are also forced low for the whole reset assertion
  assign bus.PCWrite    = pcwrite_s & rst_n;
  assign bus.IRWrite    = irwrite_s & rst_n;
  assign bus.MemWrite   = memwrite_s & rst_n;
  assign bus.RegWrite   = regwrite_s & rst_n;
  assign bus.illegal    = illegal_s & rst_n;
  assign bus.AdrSrc     = adrsrc_s;
  assign bus.ResultSrc  = resultsrc_s;
  assign bus.ALUSrcA    = srca_s;
  assign bus.ALUSrcB    = srcb_s;
  assign bus.ImmSrc     = immsrc_s;
  assign bus.ALUControl = alu_ctrl_s;
  assign bus.state_o    = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table for the main
// instruction flows plus hand-written stall, reset and parameter sequences.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mc_ctrl_if #(.ALU_CTRL_W(3)) ifc1 ();
  mc_ctrl_if #(.ALU_CTRL_W(5)) ifc2 ();

  multicycle_control #(.ALU_CTRL_W(3), .FULL_BRANCH(1), .MEM_HANDSHAKE(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1)
  );

  multicycle_control #(.ALU_CTRL_W(5), .FULL_BRANCH(0), .MEM_HANDSHAKE(0)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [3:0]  fl;
    logic        mr;
    logic [20:0] exp;
  } vec_t;

  vec_t vq[$];

  // {state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, SrcA, SrcB, ALU, ImmSrc, illegal}
  function automatic logic [20:0] ex(input logic [3:0] st, input logic pcw, input logic irw,
                                     input logic memw, input logic regw, input logic adr,
                                     input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] alu, input logic [1:0] imm, input logic ill);
    return {st, pcw, irw, memw, regw, adr, res, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [20:0] f_fetch(input logic mr);
    return ex(ST_FETCH, mr, mr, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0);
  endfunction
  function automatic logic [20:0] f_dec(input logic [1:0] imm);
    return ex(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [20:0] f_wb();
    return ex(ST_ALUWB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
  endfunction
  function automatic logic [20:0] f_trap();
    return ex(ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1);
  endfunction

  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                      input logic [3:0] fl, input logic mr, input logic [20:0] e);
    vec_t t;
    t.op = op; t.f3 = f3; t.f75 = f75; t.fl = fl; t.mr = mr; t.exp = e;
    vq.push_back(t);
  endtask

  task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic [2:0] alu);
    push(op, f3, f75, 4'h0, 1'b1, f_fetch(1'b1));
    push(op, f3, f75, 4'h0, 1'b1, f_dec(2'b00));
    if (op[5])
      push(op, f3, f75, 4'h0, 1'b1, ex(ST_EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 1'b0));
    else
      push(op, f3, f75, 4'h0, 1'b1, ex(ST_EXECI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 1'b0));
    push(op, f3, f75, 4'h0, 1'b1, f_wb());
  endtask

  task automatic br(input logic [2:0] f3, input logic [3:0] fl, input logic taken);
    push(OP_BRANCH, f3, 1'b0, fl, 1'b1, f_fetch(1'b1));
    push(OP_BRANCH, f3, 1'b0, fl, 1'b1, f_dec(2'b10));
    push(OP_BRANCH, f3, 1'b0, fl, 1'b1,
         ex(ST_BRANCH, taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0));
  endtask

  task automatic build_vectors();
    alu_instr(OP_RTYPE, 3'b000, 1'b0, 3'b000);   // add
    alu_instr(OP_RTYPE, 3'b000, 1'b1, 3'b001);   // sub
    alu_instr(OP_ITYPE, 3'b000, 1'b1, 3'b000);   // addi ignores funct7[5]
    alu_instr(OP_RTYPE, 3'b110, 1'b0, 3'b011);   // or
    alu_instr(OP_ITYPE, 3'b111, 1'b0, 3'b010);   // andi
    alu_instr(OP_RTYPE, 3'b010, 1'b0, 3'b101);   // slt
    push(OP_RTYPE, 3'b001, 1'b0, 4'h0, 1'b1, f_fetch(1'b1));
    push(OP_RTYPE, 3'b001, 1'b0, 4'h0, 1'b1, f_dec(2'b00));
    push(OP_RTYPE, 3'b001, 1'b0, 4'h0, 1'b1, f_trap());
    // lw with one stalled fetch cycle
    push(OP_LOAD, 3'b010, 1'b0, 4'h0, 1'b0, f_fetch(1'b0));
    push(OP_LOAD, 3'b010, 1'b0, 4'h0, 1'b1, f_fetch(1'b1));
    push(OP_LOAD, 3'b010, 1'b0, 4'h0, 1'b1, f_dec(2'b00));
    push(OP_LOAD, 3'b010, 1'b0, 4'h0, 1'b1, ex(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0));
    push(OP_LOAD, 3'b010, 1'b0, 4'h0, 1'b1, ex(ST_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
    push(OP_LOAD, 3'b010, 1'b0, 4'h0, 1'b1, ex(ST_MEMWB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
    // sw with one stalled write cycle
    push(OP_STORE, 3'b010, 1'b0, 4'h0, 1'b1, f_fetch(1'b1));
    push(OP_STORE, 3'b010, 1'b0, 4'h0, 1'b1, f_dec(2'b01));
    push(OP_STORE, 3'b010, 1'b0, 4'h0, 1'b1, ex(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0));
    push(OP_STORE, 3'b010, 1'b0, 4'h0, 1'b0, ex(ST_MEMWRITE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
    push(OP_STORE, 3'b010, 1'b0, 4'h0, 1'b1, ex(ST_MEMWRITE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
    // branches, flags = {Zero, Negative, Carry, Overflow}
    br(3'b000, 4'b1000, 1'b1);   // beq equal
    br(3'b001, 4'b0000, 1'b1);   // bne not equal
    br(3'b001, 4'b1000, 1'b0);   // bne equal
    br(3'b100, 4'b0100, 1'b1);   // blt N^V=1
    br(3'b101, 4'b0101, 1'b1);   // bge N^V=0
    br(3'b110, 4'b0010, 1'b0);   // bltu, no borrow
    br(3'b111, 4'b0010, 1'b1);   // bgeu, no borrow
    push(OP_BRANCH, 3'b010, 1'b0, 4'h0, 1'b1, f_fetch(1'b1));
    push(OP_BRANCH, 3'b010, 1'b0, 4'h0, 1'b1, f_dec(2'b10));
    push(OP_BRANCH, 3'b010, 1'b0, 4'h0, 1'b1, f_trap());
    // jal
    push(OP_JAL, 3'b000, 1'b0, 4'h0, 1'b1, f_fetch(1'b1));
    push(OP_JAL, 3'b000, 1'b0, 4'h0, 1'b1, f_dec(2'b11));
    push(OP_JAL, 3'b000, 1'b0, 4'h0, 1'b1, ex(ST_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0));
    push(OP_JAL, 3'b000, 1'b0, 4'h0, 1'b1, f_wb());
    // unknown opcode
    push(7'b1111111, 3'b000, 1'b0, 4'h0, 1'b1, f_fetch(1'b1));
    push(7'b1111111, 3'b000, 1'b0, 4'h0, 1'b1, f_dec(2'b00));
    push(7'b1111111, 3'b000, 1'b0, 4'h0, 1'b1, f_trap());
    push(7'b1111111, 3'b000, 1'b0, 4'h0, 1'b1, f_fetch(1'b1));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, expv);
    end
  endtask

  task automatic drv1(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                      input logic [3:0] fl, input logic mr);
    ifc1.op = op; ifc1.funct3 = f3; ifc1.funct75 = f75;
    {ifc1.Zero, ifc1.Negative, ifc1.Carry, ifc1.Overflow} = fl;
    ifc1.mem_ready = mr;
  endtask

  task automatic drv2(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                      input logic [3:0] fl);
    ifc2.op = op; ifc2.funct3 = f3; ifc2.funct75 = f75;
    {ifc2.Zero, ifc2.Negative, ifc2.Carry, ifc2.Overflow} = fl;
    ifc2.mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] lw_stall_state(input int c);
    case (c)
      0:       return ST_FETCH;
      1:       return ST_DECODE;
      2:       return ST_MEMADR;
      7:       return ST_MEMWB;
      default: return ST_MEMREAD;
    endcase
  endfunction

  logic [20:0] act1;
  assign act1 = {ifc1.state_o, ifc1.PCWrite, ifc1.IRWrite, ifc1.MemWrite, ifc1.RegWrite,
                 ifc1.AdrSrc, ifc1.ResultSrc, ifc1.ALUSrcA, ifc1.ALUSrcB, ifc1.ALUControl,
                 ifc1.ImmSrc, ifc1.illegal};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drv1(OP_RTYPE, 3'b000, 1'b0, 4'h0, 1'b1);
    drv2(OP_RTYPE, 3'b000, 1'b0, 4'h0);
    #7;
    chk("reset_state", 32'(ifc1.state_o), 32'(ST_FETCH));
    chk("reset_enables", {28'h0, ifc1.PCWrite, ifc1.IRWrite, ifc1.RegWrite, ifc1.illegal}, 32'h0);

    build_vectors();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      drv1(vq[i].op, vq[i].f3, vq[i].f75, vq[i].fl, vq[i].mr);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(act1), 32'(vq[i].exp));
      step();
    end

    // lw with three not-ready cycles in MEMREAD: 8 cycles FETCH..MEMWB
    do_reset();
    drv1(OP_LOAD, 3'b010, 1'b0, 4'h0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      ifc1.mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("lw_stall_state%0d", c), 32'(ifc1.state_o), 32'(lw_stall_state(c)));
      chk($sformatf("lw_stall_regwrite%0d", c), 32'(ifc1.RegWrite), 32'(c == 7));
      step();
    end
    chk("lw_stall_done", 32'(ifc1.state_o), 32'(ST_FETCH));

    // reset asserted while a store is held in MEMWRITE
    do_reset();
    drv1(OP_STORE, 3'b010, 1'b0, 4'h0, 1'b1);
    step();
    step();
    ifc1.mem_ready = 1'b0;
    step();
    @(negedge clk);
    chk("sw_hold_state", 32'(ifc1.state_o), 32'(ST_MEMWRITE));
    chk("sw_hold_memwrite", 32'(ifc1.MemWrite), 32'd1);
    #2;
    rst_n = 1'b0;
    ifc1.mem_ready = 1'b1;
    #1;
    chk("rst_memwrite", 32'(ifc1.MemWrite), 32'd0);
    chk("rst_state", 32'(ifc1.state_o), 32'(ST_FETCH));
    chk("rst_fetch_enables", {30'h0, ifc1.PCWrite, ifc1.IRWrite}, 32'h0);
    step();
    chk("rst_held_state", 32'(ifc1.state_o), 32'(ST_FETCH));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_irwrite", 32'(ifc1.IRWrite), 32'd1);
    step();
    chk("post_rst_decode", 32'(ifc1.state_o), 32'(ST_DECODE));

    // wide ALUControl, beq-only branching, handshake ignored
    do_reset();
    drv2(OP_RTYPE, 3'b000, 1'b1, 4'h0);
    @(negedge clk);
    chk("w5_fetch_irwrite", 32'(ifc2.IRWrite), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("w5_sub_state", 32'(ifc2.state_o), 32'(ST_EXECR));
    chk("w5_sub_alu", 32'(ifc2.ALUControl), 32'h01);
    step();
    step();
    drv2(OP_ITYPE, 3'b010, 1'b0, 4'h0);
    step();
    step();
    @(negedge clk);
    chk("w5_slt_alu", 32'(ifc2.ALUControl), 32'h05);
    step();
    step();
    drv2(OP_BRANCH, 3'b001, 1'b0, 4'h0);
    step();
    step();
    @(negedge clk);
    chk("fb0_bne_trap", 32'(ifc2.state_o), 32'(ST_TRAP));
    chk("fb0_bne_illegal", 32'(ifc2.illegal), 32'd1);
    step();
    @(negedge clk);
    chk("fb0_illegal_pulse", 32'(ifc2.illegal), 32'd0);
    drv2(OP_BRANCH, 3'b000, 1'b0, 4'b1000);
    step();
    step();
    @(negedge clk);
    chk("fb0_beq_state", 32'(ifc2.state_o), 32'(ST_BRANCH));
    chk("fb0_beq_pcwrite", 32'(ifc2.PCWrite), 32'd1);
    step();
    drv2(OP_LOAD, 3'b010, 1'b0, 4'h0);
    step();
    step();
    step();
    step();
    @(negedge clk);
    chk("nohs_lw_memwb", 32'(ifc2.state_o), 32'(ST_MEMWB));
    chk("nohs_lw_regwrite", 32'(ifc2.RegWrite), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_CTRL_W, default 3: ALUControl width, >= 3; upper bits beyond 3 SHALL be zero.
REQ-002 Parameter FULL_BRANCH, default 1: 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq only, other branches illegal.
REQ-003 Parameter MEM_HANDSHAKE, default 1: 1 = memory states wait on mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-004 clk  in  1  single clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 op  in  7  opcode of instruction register; funct3  in  3; funct75  in  1  funct7[5].
REQ-006 Zero, Negative, Carry, Overflow  in  1 each  ALU flags of current-cycle result (Carry = no-borrow on subtract).
REQ-007 mem_ready  in  1  memory accepts/returns data this cycle.
REQ-008 PCWrite  out  1  PC load; AdrSrc  out  1  0=PC,1=ALUOut; MemWrite  out  1; IRWrite  out  1.
REQ-009 ResultSrc  out  2  00=ALUOut,01=Data,10=ALUResult; ALUSrcA  out  2  00=PC,01=OldPC,10=rs1; ALUSrcB  out  2  00=rs2,01=imm,10=const 4.
REQ-010 ALUControl  out  ALU_CTRL_W; ImmSrc  out  2  00=I,01=S,10=B,11=J; RegWrite  out  1.
REQ-011 illegal  out  1  one-cycle pulse on unsupported op/funct3; state_o  out  4  current state, debug.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP; Moore outputs except PCWrite in BRANCH and memory-gated enables.
REQ-013 FETCH: AdrSrc=0, SrcA=00, SrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; -> DECODE when mem_ready, else hold.
REQ-014 DECODE: SrcA=01, SrcB=01, add (branch target); ImmSrc per op; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, other->TRAP.
REQ-015 MEMADR: SrcA=10, SrcB=01, add; ImmSrc=00 for lw, 01 for sw; -> MEMREAD (lw) or MEMWRITE (sw).
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00; -> MEMWB when mem_ready, else hold. MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-017 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle held; -> FETCH when mem_ready.
REQ-018 EXECR: SrcA=10, SrcB=00, ALU decoded; EXECI: SrcA=10, SrcB=01, ImmSrc=00, ALU decoded; both -> ALUWB.
REQ-019 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-020 BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00, ImmSrc=10; PCWrite=taken; -> FETCH.
REQ-021 taken: 000 Zero; 001 !Zero; 100 Negative^Overflow; 101 !(Negative^Overflow); 110 !Carry; 111 Carry; 010/011 -> TRAP from DECODE, never BRANCH.
REQ-022 JAL: SrcA=01, SrcB=10, add, ResultSrc=00, ImmSrc=11, PCWrite=1; -> ALUWB (link write).
REQ-023 TRAP: illegal=1, all write enables 0; -> FETCH after one cycle.
REQ-024 ALU encoding: add 000, sub 001, and 010, or 011, slt 101; R-type with funct3=000 and funct75=1 -> sub; I-type funct3=000 -> add regardless of funct75.
REQ-025 Unsupported funct3 in EXECR/EXECI (001,011,100,101,... not listed) SHALL route DECODE -> TRAP.
REQ-026 Outside named cases every enable SHALL be 0 and selects 00.
REQ-027 mem_ready low SHALL only extend FETCH/MEMREAD/MEMWRITE; no other state depends on it.

Reset
REQ-028 rst_n low SHALL force state FETCH asynchronously and hold PCWrite, IRWrite, MemWrite, RegWrite, illegal at 0 while asserted.
REQ-029 Reset mid-instruction SHALL abort it with no further write enable; first post-reset cycle is FETCH.

Structure
REQ-030 Package mc_ctrl_pkg SHALL hold state enum, opcode constants, ALU encodings, select encodings.
REQ-031 Sub-module mc_alu_decoder (combinational: mode, funct3, funct75, op[5] -> ALUControl, legal) SHALL be instantiated once.

Verification
REQ-032 add x3,x1,x2 (op 0110011, f3 000, f75 0): FETCH,DECODE,EXECR(ALUControl 000),ALUWB(RegWrite 1) -> 4 cycles.
REQ-033 lw with mem_ready low 3 cycles in MEMREAD: state held, RegWrite 0, then MEMWB RegWrite 1; total 8 cycles.
REQ-034 bne Zero=0 -> PCWrite 1 in BRANCH; bne Zero=1 -> PCWrite 0; FULL_BRANCH=0 bne -> TRAP, illegal 1 pulse.
REQ-035 jal: JAL PCWrite 1, ImmSrc 11, then ALUWB RegWrite 1, ResultSrc 00.
REQ-036 rst_n low during MEMWRITE: MemWrite 0 same cycle, state_o FETCH; release -> fetch resumes.
REQ-037 ALU_CTRL_W=5: sub yields 00001, slt 00101.
